// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC capture write path and the UDP send path.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        RST_FIFO = 2'd0,
        SETTLE   = 2'd1,
        IDLE     = 2'd2,
        BURST    = 2'd3
    } cap_state_e;

    localparam int CAP_FRAME_LEN  = 1024;
    localparam int CAP_FIFO_DEPTH = 2048;

    // UDP header adds 8 bytes; IP header adds another 20 on top of that.
    localparam int UDP_DATA_LEN  = CAP_FRAME_LEN + 8;
    localparam int UDP_TOTAL_LEN = CAP_FRAME_LEN + 28;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Write-side port bundle of the ADC capture FIFO.
interface adc_capture_ctrl_if #(
    parameter int CNT_W = 11
) ();
    logic             fifo_rst;
    logic [7:0]       fifo_din;
    logic             fifo_wr_en;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_wr_count;

    modport master (
        output fifo_rst,
        output fifo_din,
        output fifo_wr_en,
        input  fifo_full,
        input  fifo_wr_count
    );

    modport slave (
        input  fifo_rst,
        input  fifo_din,
        input  fifo_wr_en,
        output fifo_full,
        output fifo_wr_count
    );
endinterface

// File: rtl/cap_cycle_counter.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module cap_cycle_counter #(
    parameter int           W       = 10,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_32,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Write-side sequencer for the ADC capture FIFO: reset/settle, whole-frame bursts,
// and overflow recovery through a fresh FIFO reset.
module adc_capture_ctrl
    import adc_cap_pkg::*;
#(
    parameter int FRAME_LEN  = CAP_FRAME_LEN,
    parameter int FIFO_DEPTH = CAP_FIFO_DEPTH,
    parameter int CNT_W      = 11,
    parameter int RST_CYC    = 8,
    parameter int SETTLE_CYC = 16
) (
    input  logic               clk_32,
    input  logic               rst_n,
    input  logic               en_adc,
    input  logic [7:0]         addata,
    adc_capture_ctrl_if.master fifo,
    output logic               busy,
    output logic [15:0]        frame_cnt,
    output logic [7:0]         ovf_cnt
);

    localparam int CYC_MAX = max3(FRAME_LEN, RST_CYC, SETTLE_CYC);
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    localparam logic [CYC_W-1:0] RST_LOAD    = CYC_W'(RST_CYC - 1);
    localparam logic [CYC_W-1:0] SETTLE_LOAD = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] FRAME_LOAD  = CYC_W'(FRAME_LEN - 1);

    // One extra bit so a threshold equal to FIFO_DEPTH cannot wrap.
    localparam logic [CNT_W:0] ROOM_THR = (CNT_W+1)'(FIFO_DEPTH - FRAME_LEN);

    cap_state_e state_q, state_d;

    logic             fifo_rst_q, fifo_rst_d;
    logic [7:0]       fifo_din_q, fifo_din_d;
    logic             fifo_wr_en_q, fifo_wr_en_d;
    logic             busy_q, busy_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [7:0]       ovf_cnt_q, ovf_cnt_d;

    logic             cnt_load;
    logic [CYC_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic [CYC_W-1:0] cnt_val;
    logic             cnt_tc;
    logic             has_room;

    // Reset value stands in for a load at entry, so RST_FIFO lasts RST_CYC cycles from reset too.
    cap_cycle_counter #(
        .W       (CYC_W),
        .RST_VAL (RST_LOAD)
    ) u_cyc_cnt (
        .clk_32     (clk_32),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .tc_o       (cnt_tc)
    );

    assign has_room = ({1'b0, fifo.fifo_wr_count} <= ROOM_THR);

    always_comb begin
        state_d      = state_q;
        fifo_din_d   = fifo_din_q;
        fifo_wr_en_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        ovf_cnt_d    = ovf_cnt_q;
        cnt_load     = 1'b0;
        cnt_load_val = RST_LOAD;
        cnt_dec      = 1'b0;

        case (state_q)
            RST_FIFO: begin
                if (cnt_tc) begin
                    state_d      = SETTLE;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETTLE_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_tc) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            IDLE: begin
                if (en_adc && has_room) begin
                    state_d      = BURST;
                    cnt_load     = 1'b1;
                    cnt_load_val = FRAME_LOAD;
                end
            end
            BURST: begin
                if (fifo.fifo_full) begin
                    // Partial frame is thrown away by the FIFO reset that follows.
                    state_d      = RST_FIFO;
                    cnt_load     = 1'b1;
                    cnt_load_val = RST_LOAD;
                    if (ovf_cnt_q != 8'hFF) begin
                        ovf_cnt_d = ovf_cnt_q + 8'd1;
                    end
                end else begin
                    fifo_wr_en_d = 1'b1;
                    fifo_din_d   = en_adc ? addata : 8'h00;
                    if (cnt_tc) begin
                        state_d     = IDLE;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RST_FIFO;
            end
        endcase

        fifo_rst_d = (state_d == RST_FIFO);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_FIFO;
            fifo_rst_q   <= 1'b1;
            fifo_din_q   <= 8'h00;
            fifo_wr_en_q <= 1'b0;
            busy_q       <= 1'b1;
            frame_cnt_q  <= 16'd0;
            ovf_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            fifo_rst_q   <= fifo_rst_d;
            fifo_din_q   <= fifo_din_d;
            fifo_wr_en_q <= fifo_wr_en_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign fifo.fifo_rst   = fifo_rst_q;
    assign fifo.fifo_din   = fifo_din_q;
    assign fifo.fifo_wr_en = fifo_wr_en_q;
    assign busy            = busy_q;
    assign frame_cnt       = frame_cnt_q;
    assign ovf_cnt         = ovf_cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: phase-level reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_adc_capture_ctrl;

    localparam int FRAME_LEN  = 1024;
    localparam int FIFO_DEPTH = 2048;
    localparam int CNT_W      = 11;
    localparam int RST_CYC    = 8;
    localparam int SETTLE_CYC = 16;

    localparam int PH_RST    = 10;
    localparam int PH_SETTLE = 20;
    localparam int PH_IDLE   = 30;
    localparam int PH_BURST  = 40;

    logic        clk_32;
    logic        rst_n;
    logic        en_adc;
    logic [7:0]  addata;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  ovf_cnt;

    int checks = 0;
    int errors = 0;

    adc_capture_ctrl_if #(.CNT_W(CNT_W)) fifo_if ();

    adc_capture_ctrl #(
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W),
        .RST_CYC    (RST_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk_32    (clk_32),
        .rst_n     (rst_n),
        .en_adc    (en_adc),
        .addata    (addata),
        .fifo      (fifo_if),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .ovf_cnt   (ovf_cnt)
    );

    initial clk_32 = 1'b0;
    always #5 clk_32 = ~clk_32;

    task automatic cmp(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase plus elapsed cycles, stepped once per clock edge.
    int m_ph     = PH_RST;
    int m_el     = 0;
    int m_idx    = 0;
    int m_wr     = 0;
    int m_din    = 0;
    int m_frames = 0;
    int m_ovf    = 0;

    always @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = PH_RST; m_el = 0; m_idx = 0; m_wr = 0;
            m_din = 0; m_frames = 0; m_ovf = 0;
        end else begin
            m_wr = 0;
            if (m_ph == PH_RST) begin
                m_el++;
                if (m_el == RST_CYC) begin m_ph = PH_SETTLE; m_el = 0; end
            end else if (m_ph == PH_SETTLE) begin
                m_el++;
                if (m_el == SETTLE_CYC) m_ph = PH_IDLE;
            end else if (m_ph == PH_IDLE) begin
                if (en_adc && (int'(fifo_if.fifo_wr_count) <= FIFO_DEPTH - FRAME_LEN)) begin
                    m_ph = PH_BURST; m_idx = 0;
                end
            end else begin
                if (fifo_if.fifo_full) begin
                    if (m_ovf < 255) m_ovf++;
                    m_ph = PH_RST; m_el = 0;
                end else begin
                    m_wr  = 1;
                    m_din = en_adc ? int'(addata) : 0;
                    m_idx++;
                    if (m_idx == FRAME_LEN) begin
                        m_frames = (m_frames + 1) % 65536;
                        m_ph = PH_IDLE;
                    end
                end
            end
        end
    end

    always @(negedge clk_32) begin
        cmp("fifo_rst", fifo_if.fifo_rst, (m_ph == PH_RST) ? 1 : 0);
        cmp("busy", busy, (m_ph != PH_IDLE) ? 1 : 0);
        cmp("fifo_wr_en", fifo_if.fifo_wr_en, m_wr);
        cmp("frame_cnt", frame_cnt, m_frames);
        cmp("ovf_cnt", ovf_cnt, m_ovf);
        if (m_wr == 1) cmp("fifo_din", fifo_if.fifo_din, m_din);
    end

    task automatic tick();
        @(negedge clk_32);
        addata = addata + 8'd1;
    endtask

    // Counts fifo_rst/busy/wr_en samples over n cycles, starting at the next negedge.
    task automatic count_seq(input int n, output int rh, output int bh, output int wh);
        rh = 0; bh = 0; wh = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (fifo_if.fifo_rst) rh++;
            if (busy) bh++;
            if (fifo_if.fifo_wr_en) wh++;
        end
    endtask

    initial begin
        int rh, bh, wh, nwr, nz, hit;

        rst_n = 1'b0; en_adc = 1'b0; addata = 8'h00;
        fifo_if.fifo_full = 1'b0; fifo_if.fifo_wr_count = '0;

        repeat (3) @(posedge clk_32);
        #1;
        cmp("reset fifo_rst", fifo_if.fifo_rst, 1);
        cmp("reset fifo_wr_en", fifo_if.fifo_wr_en, 0);
        cmp("reset fifo_din", fifo_if.fifo_din, 0);
        cmp("reset busy", busy, 1);
        #1 rst_n = 1'b1;

        // Reset release with capture disabled
        count_seq(40, rh, bh, wh);
        cmp("A fifo_rst cycles", rh, 8);
        cmp("A busy cycles", bh, 24);
        cmp("A writes", wh, 0);

        // Ramp frame, then back-to-back second frame
        en_adc = 1'b1; addata = 8'h00;
        nwr = 0; hit = 0;
        for (int i = 0; i < 1100 && hit == 0; i++) begin
            tick();
            if (fifo_if.fifo_wr_en) begin
                if (nwr == 0) cmp("B first byte", fifo_if.fifo_din, 1);
                nwr++;
            end
            if (frame_cnt == 16'd1) hit = 1;
        end
        cmp("B frame1 reached", hit, 1);
        cmp("B frame1 writes", nwr, 1024);
        cmp("B last write strobe", fifo_if.fifo_wr_en, 1);
        tick();
        cmp("B gap", fifo_if.fifo_wr_en, 0);
        tick();
        cmp("B back-to-back start", fifo_if.fifo_wr_en, 1);

        // Drop en_adc at burst index 500
        repeat (499) tick();
        en_adc = 1'b0;
        nwr = 0; nz = 0; hit = 0;
        for (int i = 0; i < 600 && hit == 0; i++) begin
            tick();
            if (fifo_if.fifo_wr_en) begin
                nwr++;
                if (fifo_if.fifo_din == 8'h00) nz++;
            end
            if (frame_cnt == 16'd2) hit = 1;
        end
        cmp("C frame2 reached", hit, 1);
        cmp("C tail writes", nwr, 524);
        cmp("C tail zeros", nz, 524);
        count_seq(30, rh, bh, wh);
        cmp("C no further burst", wh, 0);
        cmp("C idle", bh, 0);

        // Room threshold: 1025 blocks, 1024 admits
        fifo_if.fifo_wr_count = 11'd1025;
        en_adc = 1'b1;
        count_seq(20, rh, bh, wh);
        cmp("D no room writes", wh, 0);
        cmp("D no room busy", bh, 0);
        fifo_if.fifo_wr_count = 11'd1024;
        tick();
        cmp("D start busy", busy, 1);
        cmp("D start no write yet", fifo_if.fifo_wr_en, 0);
        fifo_if.fifo_wr_count = 11'd1025;
        tick();
        cmp("D first write", fifo_if.fifo_wr_en, 1);
        hit = 0;
        for (int i = 0; i < 1100 && hit == 0; i++) begin
            tick();
            if (frame_cnt == 16'd3) hit = 1;
        end
        cmp("D frame3 reached", hit, 1);
        en_adc = 1'b0;
        repeat (3) tick();

        // Overflow at burst index 300
        fifo_if.fifo_wr_count = '0;
        en_adc = 1'b1;
        nwr = 0;
        for (int i = 0; i < 400 && nwr < 300; i++) begin
            tick();
            if (fifo_if.fifo_wr_en) nwr++;
        end
        cmp("E writes before full", nwr, 300);
        fifo_if.fifo_full = 1'b1;
        tick();
        fifo_if.fifo_full = 1'b0;
        en_adc = 1'b0;
        cmp("E write suppressed", fifo_if.fifo_wr_en, 0);
        cmp("E ovf_cnt", ovf_cnt, 1);
        cmp("E frame_cnt held", frame_cnt, 3);
        rh = fifo_if.fifo_rst ? 1 : 0;
        bh = busy ? 1 : 0;
        for (int i = 0; i < 39; i++) begin
            tick();
            if (fifo_if.fifo_rst) rh++;
            if (busy) bh++;
        end
        cmp("E fifo_rst cycles", rh, 8);
        cmp("E busy cycles", bh, 24);

        // Repeated overflow on the first burst cycle: saturation
        fifo_if.fifo_full = 1'b1;
        en_adc = 1'b1;
        repeat (300 * 26) tick();
        cmp("F ovf saturated", ovf_cnt, 255);
        cmp("F frame_cnt held", frame_cnt, 3);
        fifo_if.fifo_full = 1'b0;
        en_adc = 1'b0;
        repeat (40) tick();

        // Asynchronous reset mid-burst
        en_adc = 1'b1;
        nwr = 0;
        for (int i = 0; i < 60 && nwr < 10; i++) begin
            tick();
            if (fifo_if.fifo_wr_en) nwr++;
        end
        cmp("G burst running", nwr, 10);
        @(posedge clk_32);
        #3 rst_n = 1'b0;
        #1;
        cmp("G async wr_en", fifo_if.fifo_wr_en, 0);
        cmp("G async fifo_rst", fifo_if.fifo_rst, 1);
        cmp("G async frame_cnt", frame_cnt, 0);
        cmp("G async ovf_cnt", ovf_cnt, 0);
        en_adc = 1'b0;
        @(posedge clk_32);
        #2 rst_n = 1'b1;
        count_seq(40, rh, bh, wh);
        cmp("G fifo_rst cycles", rh, 8);
        cmp("G busy cycles", bh, 24);
        cmp("G writes", wh, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
